// File: rtl/alu_driver_if.sv
// rtl/alu_driver_if.sv - signal bundle between a command source, alu_driver and the alu
//
// Purpose: groups the request channel, the ALU-facing drive/result signals and
// the response channel so they can be passed as a single port.
//
// Signals:
//   req_valid/req_ready   request handshake
//   req_a/req_b/req_op    request operands and op code
//   alu_a/alu_b/alu_op    operand/op drive toward the alu
//   alu_en                one-cycle enable strobe toward the alu
//   alu_result            result returned by the alu
//   rsp_valid/rsp_ready   response handshake
//   rsp_result            captured result
//   busy                  driver is not idle
//   done_count            completed responses, wraps at 16 bits
//
// Modports:
//   master  command source side (also supplies alu_result from the alu)
//   slave   alu_driver side
interface alu_driver_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [1:0]       req_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_op;
    logic             alu_en;
    logic [WIDTH-1:0] alu_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;

    logic             busy;
    logic [15:0]      done_count;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_result,
        input  req_ready, alu_a, alu_b, alu_op, alu_en, rsp_valid, rsp_result,
               busy, done_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result,
        output req_ready, alu_a, alu_b, alu_op, alu_en, rsp_valid, rsp_result,
               busy, done_count
    );
endinterface

// File: rtl/alu_driver.sv
// rtl/alu_driver.sv - request-side sequencer that issues one op to the alu and returns its result
//
// Purpose: accepts one operation at a time, drives the alu operands/op, pulses
// alu_en for a single cycle, waits ALU_LAT cycles, captures the result and
// presents it on the response channel until it is taken.
//
// Parameters:
//   WIDTH    operand/result width
//   ALU_LAT  cycles from the alu_en cycle until alu_result is valid (1..15)
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   bus      alu_driver_if.slave: request, alu-side and response signals
module alu_driver #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    alu_driver_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [1:0]       r_alu_op;
    logic [WIDTH-1:0] r_rsp_result;
    logic [15:0]      r_done_count;

    logic             w_accept;
    logic             w_load;
    logic             w_dec;
    logic             w_capture;
    logic             w_rsp_fire;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_capture   = 1'b0;
        w_rsp_fire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_load      = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // The count reaching 1 marks the last wait cycle, in which
                // alu_result is already valid and can be sampled.
                if (r_cnt == 4'd1) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_fire  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand registers hold the last issued request until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= 2'd0;
        end else if (w_accept) begin
            r_alu_a  <= bus.req_a;
            r_alu_b  <= bus.req_b;
            r_alu_op <= bus.req_op;
        end
    end

    // Latency counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (w_load) begin
            r_cnt <= LAT_LOAD;
        end else if (w_dec) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Result capture; stable for the whole RESP stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_result <= '0;
        end else if (w_capture) begin
            r_rsp_result <= bus.alu_result;
        end
    end

    // Completion counter, free-running wrap at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_count <= 16'd0;
        end else if (w_rsp_fire) begin
            r_done_count <= r_done_count + 16'd1;
        end
    end

    // req_ready is gated by rst so it reads low for the whole reset pulse,
    // not just after the state register has been cleared.
    assign bus.req_ready  = (r_state == S_IDLE) && !rst;
    assign bus.alu_en     = (r_state == S_ISSUE);
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_op     = r_alu_op;
    assign bus.rsp_result = r_rsp_result;
    assign bus.done_count = r_done_count;

endmodule

// File: tb/tb_alu_driver.sv
// tb/tb_alu_driver.sv - self-checking bench for alu_driver (ALU_LAT 1 and 3 instances)
module tb_alu_driver;
    localparam int W = 32;
    localparam int LAT [2] = '{1, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic wrap_req = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_driver_if #(.WIDTH(W)) bus1 ();
    alu_driver_if #(.WIDTH(W)) bus3 ();

    alu_driver #(.WIDTH(W), .ALU_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    alu_driver #(.WIDTH(W), .ALU_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    function automatic logic [W-1:0] alu_fn(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    // Registered ALU models
    always @(posedge clk) if (bus1.alu_en) bus1.alu_result <= alu_fn(bus1.alu_op, bus1.alu_a, bus1.alu_b);
    always @(posedge clk) if (bus3.alu_en) bus3.alu_result <= alu_fn(bus3.alu_op, bus3.alu_a, bus3.alu_b);

    task automatic chk(input string name, input int lat, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (lat%0d) cycle %0d: got 0x%0h, want 0x%0h", name, lat, cyc, act, exp);
        end
    endtask

    // Model: m_t = cycles since the accepting edge (0 = idle). ISSUE is cycle 1,
    // the response is up from cycle LAT+2 until the rsp handshake.
    int          m_t    [2];
    logic [W-1:0] m_a   [2];
    logic [W-1:0] m_b   [2];
    logic [1:0]  m_op   [2];
    logic [W-1:0] m_res [2];
    logic [15:0] m_done [2];

    always @(negedge clk) begin : compare
        logic         s_rdy [2];
        logic         s_en  [2];
        logic         s_bsy [2];
        logic         s_vld [2];
        logic [W-1:0] s_res [2];
        logic [W-1:0] s_a   [2];
        logic [W-1:0] s_b   [2];
        logic [1:0]   s_op  [2];
        logic [15:0]  s_dn  [2];
        logic         i_vld [2];
        logic         i_rdy [2];
        logic [W-1:0] i_a   [2];
        logic [W-1:0] i_b   [2];
        logic [1:0]   i_op  [2];
        s_rdy[0] = bus1.req_ready;  s_rdy[1] = bus3.req_ready;
        s_en[0]  = bus1.alu_en;     s_en[1]  = bus3.alu_en;
        s_bsy[0] = bus1.busy;       s_bsy[1] = bus3.busy;
        s_vld[0] = bus1.rsp_valid;  s_vld[1] = bus3.rsp_valid;
        s_res[0] = bus1.rsp_result; s_res[1] = bus3.rsp_result;
        s_a[0]   = bus1.alu_a;      s_a[1]   = bus3.alu_a;
        s_b[0]   = bus1.alu_b;      s_b[1]   = bus3.alu_b;
        s_op[0]  = bus1.alu_op;     s_op[1]  = bus3.alu_op;
        s_dn[0]  = bus1.done_count; s_dn[1]  = bus3.done_count;
        i_vld[0] = bus1.req_valid;  i_vld[1] = bus3.req_valid;
        i_rdy[0] = bus1.rsp_ready;  i_rdy[1] = bus3.rsp_ready;
        i_a[0]   = bus1.req_a;      i_a[1]   = bus3.req_a;
        i_b[0]   = bus1.req_b;      i_b[1]   = bus3.req_b;
        i_op[0]  = bus1.req_op;     i_op[1]  = bus3.req_op;
        if (wrap_req) m_done[0] = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_t[i] = 0; m_a[i] = '0; m_b[i] = '0; m_op[i] = 2'd0;
                m_res[i] = '0; m_done[i] = 16'd0;
            end
            chk("req_ready",  LAT[i], s_rdy[i], (m_t[i] == 0) && !rst);
            chk("alu_en",     LAT[i], s_en[i],  m_t[i] == 1);
            chk("busy",       LAT[i], s_bsy[i], m_t[i] != 0);
            chk("rsp_valid",  LAT[i], s_vld[i], m_t[i] >= LAT[i] + 2);
            chk("rsp_result", LAT[i], s_res[i], m_res[i]);
            chk("alu_a",      LAT[i], s_a[i],   m_a[i]);
            chk("alu_b",      LAT[i], s_b[i],   m_b[i]);
            chk("alu_op",     LAT[i], s_op[i],  m_op[i]);
            chk("done_count", LAT[i], s_dn[i],  m_done[i]);
            if (!rst) begin
                if (m_t[i] == 0) begin
                    if (i_vld[i]) begin
                        m_t[i] = 1; m_a[i] = i_a[i]; m_b[i] = i_b[i]; m_op[i] = i_op[i];
                    end
                end else if (m_t[i] < LAT[i] + 2) begin
                    m_t[i]++;
                    if (m_t[i] == LAT[i] + 2) m_res[i] = alu_fn(m_op[i], m_a[i], m_b[i]);
                end else if (i_rdy[i]) begin
                    m_t[i] = 0;
                    m_done[i]++;
                end
            end
        end
    end

    // Presents a request on bus1; returns one cycle after the accepting edge.
    task automatic issue1(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        bit got = 1'b0;
        bus1.req_valid = 1'b1; bus1.req_a = a; bus1.req_b = b; bus1.req_op = op;
        for (int n = 0; n < 32 && !got; n++) begin
            @(negedge clk);
            got = bus1.req_ready;
            @(posedge clk); #1;
        end
        bus1.req_valid = 1'b0;
        if (!got) chk("issue1_timeout", 1, 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int en_cnt;
        bit seen;
        bit got;
        int acc [4];
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        ta = '{32'd100, 32'd7, 32'hFFFF_FFFF, 32'd5};
        tb = '{32'd23,  32'd2, 32'd1,         32'd9};

        bus1.req_valid = 1'b0; bus1.req_a = '0; bus1.req_b = '0; bus1.req_op = 2'd0; bus1.rsp_ready = 1'b0;
        bus3.req_valid = 1'b0; bus3.req_a = '0; bus3.req_b = '0; bus3.req_op = 2'd0; bus3.rsp_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 1, bus1.req_ready, 0);
        chk("rst_alu_en",    1, bus1.alu_en, 0);
        chk("rst_done",      1, bus1.done_count, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 1, bus1.req_ready, 1);
        @(posedge clk); #1;

        // Add
        bus1.rsp_ready = 1'b1;
        issue1(32'd19260817, 32'd99999999, 2'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k <= 2) chk("add_en", 1, bus1.alu_en, k == 1);
            if (k == 3) begin
                chk("add_valid",  1, bus1.rsp_valid, 1);
                chk("add_result", 1, bus1.rsp_result, 32'd119260816);
            end
            if (k == 4) begin
                chk("add_done",  1, bus1.done_count, 1);
                chk("add_ready", 1, bus1.req_ready, 1);
            end
            @(posedge clk); #1;
        end

        // Subtract with wrap and backpressure; inputs churned during the stall
        bus1.rsp_ready = 1'b0;
        issue1(32'd19260817, 32'd99999999, 2'd1);
        for (int k = 1; k <= 9; k++) begin
            bus1.req_valid = (k <= 7);
            bus1.req_a = 32'hDEAD_0000 + W'(k); bus1.req_b = W'(k); bus1.req_op = 2'd2;
            bus1.rsp_ready = (k == 8);
            @(negedge clk);
            if (k >= 3 && k <= 8) begin
                chk("sub_valid",  1, bus1.rsp_valid, 1);
                chk("sub_result", 1, bus1.rsp_result, 32'd4214228114);
                chk("sub_ready",  1, bus1.req_ready, 0);
            end
            if (k == 9) begin
                chk("sub_done",   1, bus1.done_count, 2);
                chk("sub_hold_a", 1, bus1.alu_a, 32'd19260817);
            end
            @(posedge clk); #1;
        end

        // req_valid pulse while in RESP is ignored
        bus1.rsp_ready = 1'b0;
        issue1(32'd1000, 32'd1, 2'd1);
        en_cnt = 1;
        for (int k = 1; k <= 7; k++) begin
            bus1.req_valid = (k == 3); bus1.req_a = 32'd77;
            bus1.rsp_ready = (k == 5);
            @(negedge clk);
            if (k > 1 && bus1.alu_en) en_cnt++;
            if (k == 3) chk("ign_result", 1, bus1.rsp_result, 32'd999);
            @(posedge clk); #1;
        end
        chk("ign_en_pulses", 1, en_cnt, 1);
        chk("ign_alu_a", 1, bus1.alu_a, 32'd1000);

        // Reset during ISSUE: alu_en drops at once
        bus1.rsp_ready = 1'b1;
        issue1(32'd5, 32'd6, 2'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_issue_en",   1, bus1.alu_en, 0);
        chk("rst_issue_done", 1, bus1.done_count, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Reset during WAIT
        issue1(32'd7, 32'd8, 2'd0);
        @(negedge clk);
        chk("wait_en", 1, bus1.alu_en, 1);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_busy",  1, bus1.busy, 0);
        chk("rst_wait_alu_a", 1, bus1.alu_a, 0);
        chk("rst_wait_vld",   1, bus1.rsp_valid, 0);
        @(posedge clk); #1; rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen |= bus1.rsp_valid;
            @(posedge clk); #1;
        end
        chk("rst_no_rsp", 1, seen, 0);
        issue1(32'd3, 32'd4, 2'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk("after_rst_done",   1, bus1.done_count, 1);
        chk("after_rst_result", 1, bus1.rsp_result, 32'd7);

        // Counter wrap
        force dut1.r_done_count = 16'hFFFF;
        wrap_req = 1'b1;
        #1 release dut1.r_done_count;
        @(negedge clk);
        chk("wrap_pre", 1, bus1.done_count, 16'hFFFF);
        @(posedge clk); #1; wrap_req = 1'b0;
        issue1(32'd1, 32'd1, 2'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk("wrap_done", 1, bus1.done_count, 16'h0000);

        // Back-to-back throughput on the ALU_LAT=3 instance
        for (int r = 0; r < 4; r++) begin
            bus3.req_valid = 1'b1; bus3.req_a = ta[r]; bus3.req_b = tb[r]; bus3.req_op = 2'(r % 2);
            got = 1'b0;
            acc[r] = 0;
            for (int n = 0; n < 32 && !got; n++) begin
                @(negedge clk);
                got = bus3.req_ready;
                @(posedge clk);
                if (got) acc[r] = cyc;
                #1;
            end
            if (!got) chk("tput_timeout", 3, 0, 1);
        end
        bus3.req_valid = 1'b0;
        for (int r = 1; r < 4; r++) chk("tput_spacing", 3, acc[r] - acc[r-1], 6);
        repeat (8) begin @(posedge clk); #1; end
        chk("tput_done",   3, bus3.done_count, 4);
        chk("tput_last",   3, bus3.rsp_result, 32'hFFFF_FFFC);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
